// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin scheduler sharing one UART transmitter among
// N_REQ byte producers. A grant latches the winner's byte, pulses tx_start and
// req_ack, then holds further grants off until the transmitter reports tx_done.
// Optional WAIT-state watchdog is built when UART_ARB_TIMEOUT_EN is defined;
// without it arb_err is tied low and WAIT holds until tx_done.
module uart_tx_arbiter #(
  parameter int N_REQ          = 4,
  parameter int TIMEOUT_CYCLES = 2_000_000
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic [N_REQ-1:0]         req_valid_i,
  input  logic [N_REQ*8-1:0]       req_data_i,
  output logic [N_REQ-1:0]         req_ack_o,
  output logic [$clog2(N_REQ)-1:0] grant_id_o,
  output logic                     arb_busy_o,
  output logic                     arb_err_o,
  output logic [7:0]               tx_data_o,
  output logic                     tx_start_o,
  input  logic                     tx_busy_i,
  input  logic                     tx_done_i
);

  localparam int IdW = $clog2(N_REQ);

  typedef enum logic [1:0] {
    IDLE,
    START,
    WAIT
  } state_e;

  state_e           state_q;
  logic [IdW-1:0]   last_grant_q;
  logic [IdW-1:0]   grant_id_q;
  logic [N_REQ-1:0] req_ack_q;
  logic             arb_busy_q;
  logic [7:0]       tx_data_q;
  logic             tx_start_q;

  logic [IdW-1:0]   grant_d;
  logic             grant_vld_d;
  logic [N_REQ-1:0] ack_d;
  logic [7:0]       data_d;

`ifdef UART_ARB_TIMEOUT_EN
  logic [31:0]      wd_cnt_q;
  logic             arb_err_q;
`endif

  // Pick the first pending requester after the last one served, wrapping around.
  always_comb begin
    int cand;
    cand        = 0;
    grant_d     = '0;
    grant_vld_d = 1'b0;
    ack_d       = '0;
    for (int off = N_REQ; off >= 1; off--) begin
      cand = (int'(last_grant_q) + off) % N_REQ;
      if (req_valid_i[cand[IdW-1:0]]) begin
        grant_d     = cand[IdW-1:0];
        grant_vld_d = 1'b1;
      end
    end
    ack_d[grant_d] = 1'b1;
    data_d         = req_data_i[8*grant_d +: 8];
  end

  // Grant FSM with all outputs registered; strobes default low every cycle.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= IDLE;
      last_grant_q <= IdW'(N_REQ - 1);
      grant_id_q   <= '0;
      req_ack_q    <= '0;
      arb_busy_q   <= 1'b0;
      tx_data_q    <= 8'h00;
      tx_start_q   <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
      wd_cnt_q     <= '0;
      arb_err_q    <= 1'b0;
`endif
    end else begin
      req_ack_q  <= '0;
      tx_start_q <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
      arb_err_q  <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (grant_vld_d && !tx_busy_i) begin
            state_q      <= START;
            tx_data_q    <= data_d;
            grant_id_q   <= grant_d;
            req_ack_q    <= ack_d;
            tx_start_q   <= 1'b1;
            arb_busy_q   <= 1'b1;
            last_grant_q <= grant_d;
          end
        end
        START: begin
          state_q <= WAIT;
`ifdef UART_ARB_TIMEOUT_EN
          wd_cnt_q <= '0;
`endif
        end
        WAIT: begin
          if (tx_done_i) begin
            state_q    <= IDLE;
            arb_busy_q <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
          end else if (wd_cnt_q == 32'(TIMEOUT_CYCLES - 1)) begin
            state_q    <= IDLE;
            arb_busy_q <= 1'b0;
            arb_err_q  <= 1'b1;
          end else begin
            wd_cnt_q <= wd_cnt_q + 32'd1;
`endif
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign req_ack_o  = req_ack_q;
  assign grant_id_o = grant_id_q;
  assign arb_busy_o = arb_busy_q;
  assign tx_data_o  = tx_data_q;
  assign tx_start_o = tx_start_q;

`ifdef UART_ARB_TIMEOUT_EN
  assign arb_err_o = arb_err_q;
`else
  assign arb_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed testbench for uart_tx_arbiter (N_REQ=4, TIMEOUT_CYCLES=100).
// The watchdog scenario is exercised when UART_ARB_TIMEOUT_EN is defined,
// otherwise the bench checks that WAIT holds with arb_err low.
module tb_uart_tx_arbiter;

  logic        clk;
  logic        reset;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ack;
  logic [1:0]  grant_id;
  logic        arb_busy;
  logic        arb_err;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_busy;
  logic        tx_done;

  int checks = 0;
  int errors = 0;

  uart_tx_arbiter #(
    .N_REQ          (4),
    .TIMEOUT_CYCLES (100)
  ) dut (
    .clk_i       (clk),
    .reset_i     (reset),
    .req_valid_i (req_valid),
    .req_data_i  (req_data),
    .req_ack_o   (req_ack),
    .grant_id_o  (grant_id),
    .arb_busy_o  (arb_busy),
    .arb_err_o   (arb_err),
    .tx_data_o   (tx_data),
    .tx_start_o  (tx_start),
    .tx_busy_i   (tx_busy),
    .tx_done_i   (tx_done)
  );

  // Free-running 10-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Global time limit so the bench can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: got no end of run, expected finish before limit");
    $fatal(1, "[TB] time limit expired");
  end

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reset DUT and idle all inputs.
  task automatic do_reset();
    reset     = 1'b1;
    req_valid = 4'b0000;
    req_data  = 32'h0;
    tx_busy   = 1'b0;
    tx_done   = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Play a transmitter frame of len busy cycles ending with a tx_done pulse.
  task automatic play_frame(input int len);
    tx_busy = 1'b1;
    repeat (len) tick();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    tx_busy = 1'b0;
  endtask

  // Wait up to limit cycles for tx_start; report whether and when it came.
  task automatic wait_start(input int limit, output bit seen, output int waited);
    seen   = 1'b0;
    waited = 0;
    while (!seen && waited < limit) begin
      tick();
      waited++;
      if (tx_start === 1'b1) seen = 1'b1;
    end
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    req_valid = 4'b1111;
    req_data  = 32'hDEADBEEF;
    tx_busy   = 1'b0;
    tx_done   = 1'b0;
    tick();
    tick();
    checks++;
    if (req_ack !== 4'b0000) begin errors++; $display("[TB] FAIL reset_ack: got %b expected 0000", req_ack); end
    checks++;
    if (grant_id !== 2'd0) begin errors++; $display("[TB] FAIL reset_grant_id: got %0d expected 0", grant_id); end
    checks++;
    if (arb_busy !== 1'b0 || arb_err !== 1'b0 || tx_start !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_flags: got busy=%b err=%b start=%b expected 0 0 0", arb_busy, arb_err, tx_start);
    end
    checks++;
    if (tx_data !== 8'h00) begin errors++; $display("[TB] FAIL reset_tx_data: got %h expected 00", tx_data); end
    req_valid = 4'b0000;
    reset     = 1'b0;
  endtask

  task automatic test_single();
    int unstable;
    do_reset();
    req_data  = 32'h00A5_0000;
    req_valid = 4'b0100;
    tick();
    checks++;
    if (tx_start !== 1'b1 || req_ack !== 4'b0100) begin
      errors++;
      $display("[TB] FAIL single_start_ack: got start=%b ack=%b expected 1 0100", tx_start, req_ack);
    end
    checks++;
    if (grant_id !== 2'd2 || tx_data !== 8'hA5 || arb_busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL single_grant: got id=%0d data=%h busy=%b expected 2 a5 1", grant_id, tx_data, arb_busy);
    end
    req_valid = 4'b0000;
    tick();
    checks++;
    if (tx_start !== 1'b0 || req_ack !== 4'b0000 || arb_busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL single_pulse_width: got start=%b ack=%b busy=%b expected 0 0000 1", tx_start, req_ack, arb_busy);
    end
    tx_busy  = 1'b1;
    unstable = 0;
    repeat (6) begin
      tick();
      if (tx_data !== 8'hA5 || arb_busy !== 1'b1 || tx_start !== 1'b0) unstable++;
    end
    checks++;
    if (unstable !== 0) begin errors++; $display("[TB] FAIL single_frame_hold: got %0d bad cycles expected 0", unstable); end
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    tx_busy = 1'b0;
    checks++;
    if (arb_busy !== 1'b0) begin errors++; $display("[TB] FAIL single_busy_fall: got %b expected 0", arb_busy); end
    tick();
    checks++;
    if (tx_start !== 1'b0) begin errors++; $display("[TB] FAIL single_no_regrant: got %b expected 0", tx_start); end
  endtask

  task automatic test_round_robin();
    int exp_seq[5] = '{0, 1, 2, 3, 0};
    bit seen;
    int waited;
    int overlap;
    logic [7:0] exp_byte;
    logic [3:0] exp_ack;
    do_reset();
    req_data  = {8'h13, 8'h12, 8'h11, 8'h10};
    req_valid = 4'b1111;
    overlap   = 0;
    for (int g = 0; g < 5; g++) begin
      exp_byte = 8'h10 + 8'(exp_seq[g]);
      exp_ack  = 4'b0001 << exp_seq[g];
      wait_start(6, seen, waited);
      checks++;
      if (!seen || waited !== 1) begin
        errors++;
        $display("[TB] FAIL rr_latency_%0d: got seen=%b after %0d cycles expected seen after 1", g, seen, waited);
      end
      checks++;
      if (grant_id !== 2'(exp_seq[g]) || tx_data !== exp_byte || req_ack !== exp_ack) begin
        errors++;
        $display("[TB] FAIL rr_grant_%0d: got id=%0d data=%h ack=%b expected %0d %h %b",
                 g, grant_id, tx_data, req_ack, exp_seq[g], exp_byte, exp_ack);
      end
      tick();
      tx_busy = 1'b1;
      repeat (3) begin
        tick();
        if (tx_start !== 1'b0 || arb_busy !== 1'b1) overlap++;
      end
      tx_done = 1'b1;
      tick();
      tx_done = 1'b0;
      tx_busy = 1'b0;
    end
    checks++;
    if (overlap !== 0) begin errors++; $display("[TB] FAIL rr_overlap: got %0d bad cycles expected 0", overlap); end
    req_valid = 4'b0000;
    tick();
    play_frame(2);
  endtask

  task automatic test_rerequest();
    bit seen;
    int waited;
    do_reset();
    req_data  = 32'h2300_2100;
    req_valid = 4'b1010;
    wait_start(4, seen, waited);
    checks++;
    if (!seen || grant_id !== 2'd1 || tx_data !== 8'h21) begin
      errors++;
      $display("[TB] FAIL rereq_first: got seen=%b id=%0d data=%h expected 1 1 21", seen, grant_id, tx_data);
    end
    req_data = 32'h2300_2200;
    tick();
    play_frame(3);
    wait_start(4, seen, waited);
    checks++;
    if (!seen || grant_id !== 2'd3 || tx_data !== 8'h23) begin
      errors++;
      $display("[TB] FAIL rereq_pending_first: got seen=%b id=%0d data=%h expected 1 3 23", seen, grant_id, tx_data);
    end
    req_valid = 4'b0010;
    tick();
    play_frame(3);
    wait_start(4, seen, waited);
    checks++;
    if (!seen || grant_id !== 2'd1 || tx_data !== 8'h22) begin
      errors++;
      $display("[TB] FAIL rereq_second: got seen=%b id=%0d data=%h expected 1 1 22", seen, grant_id, tx_data);
    end
    req_valid = 4'b0000;
    tick();
    play_frame(2);
  endtask

  task automatic test_busy_hold();
    bit seen;
    int waited;
    int early;
    do_reset();
    req_data  = 32'h0000_0077;
    tx_busy   = 1'b1;
    req_valid = 4'b0001;
    early     = 0;
    repeat (5) begin
      tick();
      if (tx_start !== 1'b0 || arb_busy !== 1'b0) early++;
    end
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    if (tx_start !== 1'b0 || arb_busy !== 1'b0) early++;
    checks++;
    if (early !== 0) begin errors++; $display("[TB] FAIL busy_hold: got %0d premature grant cycles expected 0", early); end
    tx_busy = 1'b0;
    wait_start(2, seen, waited);
    checks++;
    if (!seen || grant_id !== 2'd0 || tx_data !== 8'h77) begin
      errors++;
      $display("[TB] FAIL busy_release: got seen=%b id=%0d data=%h expected 1 0 77", seen, grant_id, tx_data);
    end
    req_valid = 4'b0000;
    tick();
    play_frame(2);
  endtask

  task automatic test_reset_mid_frame();
    bit seen;
    int waited;
    do_reset();
    req_data  = 32'h4400_0040;
    req_valid = 4'b0100;
    wait_start(4, seen, waited);
    checks++;
    if (!seen || grant_id !== 2'd2) begin
      errors++;
      $display("[TB] FAIL midrst_grant: got seen=%b id=%0d expected 1 2", seen, grant_id);
    end
    req_valid = 4'b0000;
    tick();
    tx_busy = 1'b1;
    tick();
    tick();
    reset   = 1'b1;
    tx_busy = 1'b0;
    tick();
    checks++;
    if (arb_busy !== 1'b0 || req_ack !== 4'b0000 || tx_start !== 1'b0 || arb_err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midrst_flags: got busy=%b ack=%b start=%b err=%b expected 0 0000 0 0",
               arb_busy, req_ack, tx_start, arb_err);
    end
    checks++;
    if (grant_id !== 2'd0 || tx_data !== 8'h00) begin
      errors++;
      $display("[TB] FAIL midrst_regs: got id=%0d data=%h expected 0 00", grant_id, tx_data);
    end
    reset     = 1'b0;
    req_data  = 32'h4400_0040;
    req_valid = 4'b1001;
    wait_start(4, seen, waited);
    checks++;
    if (!seen || grant_id !== 2'd0 || tx_data !== 8'h40) begin
      errors++;
      $display("[TB] FAIL midrst_next_grant: got seen=%b id=%0d data=%h expected 1 0 40", seen, grant_id, tx_data);
    end
    req_valid = 4'b0000;
    tick();
    play_frame(2);
  endtask

`ifdef UART_ARB_TIMEOUT_EN
  task automatic test_timeout();
    bit seen;
    int waited;
    int early;
    do_reset();
    req_data  = 32'h3300_1100;
    req_valid = 4'b0010;
    wait_start(4, seen, waited);
    checks++;
    if (!seen || grant_id !== 2'd1) begin
      errors++;
      $display("[TB] FAIL wd_grant: got seen=%b id=%0d expected 1 1", seen, grant_id);
    end
    req_valid = 4'b1000;
    tick();
    early = 0;
    for (int k = 1; k < 100; k++) begin
      tick();
      if (arb_err !== 1'b0 || arb_busy !== 1'b1) early++;
    end
    checks++;
    if (early !== 0) begin errors++; $display("[TB] FAIL wd_early: got %0d bad cycles expected 0", early); end
    tick();
    checks++;
    if (arb_err !== 1'b1 || arb_busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL wd_abort: got err=%b busy=%b expected 1 0", arb_err, arb_busy);
    end
    tick();
    checks++;
    if (arb_err !== 1'b0 || tx_start !== 1'b1 || grant_id !== 2'd3 || tx_data !== 8'h33) begin
      errors++;
      $display("[TB] FAIL wd_next_grant: got err=%b start=%b id=%0d data=%h expected 0 1 3 33",
               arb_err, tx_start, grant_id, tx_data);
    end
    req_valid = 4'b0000;
    tick();
    play_frame(2);
  endtask
`else
  task automatic test_no_timeout();
    bit seen;
    int waited;
    int bad;
    do_reset();
    req_data  = 32'h0000_5500;
    req_valid = 4'b0010;
    wait_start(4, seen, waited);
    checks++;
    if (!seen || grant_id !== 2'd1) begin
      errors++;
      $display("[TB] FAIL nowd_grant: got seen=%b id=%0d expected 1 1", seen, grant_id);
    end
    req_valid = 4'b0000;
    tick();
    bad = 0;
    repeat (150) begin
      tick();
      if (arb_err !== 1'b0 || arb_busy !== 1'b1) bad++;
    end
    checks++;
    if (bad !== 0) begin errors++; $display("[TB] FAIL nowd_hold: got %0d bad cycles expected 0", bad); end
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    checks++;
    if (arb_busy !== 1'b0) begin errors++; $display("[TB] FAIL nowd_release: got %b expected 0", arb_busy); end
  endtask
`endif

  // Run every scenario in order and report.
  initial begin
    reset     = 1'b1;
    req_valid = 4'b0000;
    req_data  = 32'h0;
    tx_busy   = 1'b0;
    tx_done   = 1'b0;
    $display("[TB] starting uart_tx_arbiter bench");
    test_reset();
    test_single();
    test_round_robin();
    test_rerequest();
    test_busy_hold();
    test_reset_mid_frame();
`ifdef UART_ARB_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
